// File: rtl/costas_lock_detect.sv
// Costas loop lock detector. Integrates |I|-|Q| over a window of valid samples
// and debounces the resulting metric into a lock flag with a hysteresis FSM.
//
// state    | meaning
// UNLOCKED | no lock, counting nothing
// ACQUIRE  | no lock yet, cnt consecutive good windows seen
// LOCKED   | locked, last window was not bad
// HOLD     | still locked, cnt consecutive bad windows seen
module costas_lock_detect #(
    parameter int                 DATA_WIDTH   = 16,
    parameter int                 WIN_LOG2     = 10,
    parameter logic signed [31:0] LOCK_THR     = 32'sd1000000,
    parameter logic signed [31:0] UNLOCK_THR   = 32'sd200000,
    parameter int                 LOCK_COUNT   = 4,
    parameter int                 UNLOCK_COUNT = 2,
    localparam int                ACC_W        = DATA_WIDTH + 1 + WIN_LOG2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    output logic [ACC_W-1:0]      metric,
    output logic                  metric_valid,
    output logic                  lock,
    output logic [1:0]            lock_state
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        ACQUIRE  = 2'b01,
        LOCKED   = 2'b10,
        HOLD     = 2'b11
    } state_t;

    // Most negative input maps to the most positive value instead of wrapping.
    function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic [DATA_WIDTH-1:0] x);
        if (!x[DATA_WIDTH-1])
            return x;
        else if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}})
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            return -x;
    endfunction

    logic [DATA_WIDTH-1:0]   abs_i;
    logic [DATA_WIDTH-1:0]   abs_q;
    logic                    v1;
    logic signed [DATA_WIDTH:0] diff;
    logic signed [ACC_W-1:0] diff_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic [WIN_LOG2-1:0]     scnt;
    logic signed [31:0]      metric32;
    logic                    good;
    logic                    bad;
    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              cnt;
    logic [2:0]              cnt_nxt;
    logic [2:0]              cnt_inc;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            v1    <= 1'b0;
            abs_i <= '0;
            abs_q <= '0;
        end else begin
            v1 <= in_valid & ~clr;
            if (in_valid) begin
                abs_i <= sat_abs(i_in);
                abs_q <= sat_abs(q_in);
            end
        end
    end

    assign diff     = $signed({1'b0, abs_i}) - $signed({1'b0, abs_q});
    assign diff_ext = ACC_W'(diff);
    assign acc_sum  = acc + diff_ext;

    // clr also drops whatever sample is sitting in stage 1 this cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc          <= '0;
            scnt         <= '0;
            metric       <= '0;
            metric_valid <= 1'b0;
        end else if (clr) begin
            acc          <= '0;
            scnt         <= '0;
            metric_valid <= 1'b0;
        end else begin
            metric_valid <= 1'b0;
            if (v1) begin
                scnt <= scnt + WIN_LOG2'(1);
                if (&scnt) begin
                    metric       <= acc_sum;
                    metric_valid <= 1'b1;
                    acc          <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    assign metric32 = 32'($signed(metric));
    assign good     = (metric32 >= LOCK_THR);
    assign bad      = (metric32 < UNLOCK_THR);
    assign cnt_inc  = cnt + 3'd1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= UNLOCKED;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = UNLOCKED;
            cnt_nxt   = '0;
        end else if (metric_valid) begin
            case (state)
                UNLOCKED: begin
                    cnt_nxt = '0;
                    if (good) begin
                        if (LOCK_COUNT == 1) begin
                            state_nxt = LOCKED;
                        end else begin
                            state_nxt = ACQUIRE;
                            cnt_nxt   = 3'd1;
                        end
                    end
                end
                ACQUIRE: begin
                    if (!good) begin
                        state_nxt = UNLOCKED;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == 3'(LOCK_COUNT)) begin
                        state_nxt = LOCKED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                LOCKED: begin
                    cnt_nxt = '0;
                    if (bad) begin
                        if (UNLOCK_COUNT == 1) begin
                            state_nxt = UNLOCKED;
                        end else begin
                            state_nxt = HOLD;
                            cnt_nxt   = 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (!bad) begin
                        state_nxt = LOCKED;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == 3'(UNLOCK_COUNT)) begin
                        state_nxt = UNLOCKED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = UNLOCKED;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign lock       = state[1];
    assign lock_state = state;

endmodule

// File: doc/costas_lock_detect.md
# costas_lock_detect

Lock detector for the Costas carrier-recovery loop. It consumes the loop's low-pass-filtered in-phase and quadrature arms (I ≈ A·cosθ, Q ≈ A·sinθ) and integrates |I| − |Q| over a fixed window of valid samples to produce a signed lock metric. A hysteresis state machine turns the metric into a debounced `lock` flag, which gates downstream symbol recovery and drives the board status LED.

## Interface
Parameters:
- DATA_WIDTH, 16: width of signed I/Q inputs
- WIN_LOG2, 10: window length is 2^WIN_LOG2 valid samples
- LOCK_THR, 32'sd1000000: signed metric threshold for entering lock
- UNLOCK_THR, 32'sd200000: signed metric threshold below which a window counts as bad; must be ≤ LOCK_THR
- LOCK_COUNT, 4: consecutive good windows required to declare lock (≥1)
- UNLOCK_COUNT, 2: consecutive bad windows required to drop lock (≥1)

Ports (ACC_W = DATA_WIDTH+1+WIN_LOG2):
- sys_clk  in  1  single clock for all logic
- sys_rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous restart of window and FSM
- in_valid  in  1  qualifies i_in/q_in
- i_in  in  DATA_WIDTH  signed filtered I arm
- q_in  in  DATA_WIDTH  signed filtered Q arm
- metric  out  ACC_W  signed window sum of |I|−|Q|, held between windows
- metric_valid  out  1  one-cycle pulse when metric updates
- lock  out  1  debounced lock flag
- lock_state  out  2  FSM state encoding (debug)

## Operation
- Stage 1 (registered): |i_in|, |q_in| with saturation (−2^(DATA_WIDTH−1) → 2^(DATA_WIDTH−1)−1); valid is carried alongside.
- Stage 2: d = |I|−|Q| (DATA_WIDTH+1 bits signed), sign-extended and added into a ACC_W-bit accumulator. The accumulator cannot overflow. A WIN_LOG2-bit sample counter counts stage-1-valid samples.
- On the sample at which the counter wraps (2^WIN_LOG2-th sample): metric ← acc + d, metric_valid = 1, and the accumulator restarts at 0 (not at d). The counter wraps to 0.
- Comparisons sign-extend metric to 32 bits. A window is good when metric ≥ LOCK_THR and bad when metric < UNLOCK_THR.
- FSM, which is evaluated only on metric_valid, with a 3-bit window counter cnt:
  - UNLOCKED (00, lock=0): on a good window → ACQUIRE with cnt=1, or → LOCKED directly if LOCK_COUNT==1.
  - ACQUIRE (01, lock=0): on a good window cnt++ and → LOCKED when cnt reaches LOCK_COUNT. Any non-good window → UNLOCKED with cnt=0.
  - LOCKED (10, lock=1): on a bad window → HOLD with cnt=1, or → UNLOCKED if UNLOCK_COUNT==1. Otherwise stay.
  - HOLD (11, lock=1): on a bad window cnt++ and → UNLOCKED when cnt reaches UNLOCK_COUNT. Any non-bad window → LOCKED with cnt=0.
- The hysteresis band (UNLOCK_THR ≤ metric < LOCK_THR) breaks an acquisition and sustains a lock.
- clr: clears the pipeline valids, accumulator, sample counter and cnt, and puts the FSM in UNLOCKED (lock=0). metric keeps its last value. clr dominates an in_valid asserted in the same cycle, so that sample is discarded. Samples already in stage 1 when clr asserts are also discarded.

## Timing
- Reset values: metric=0, metric_valid=0, lock=0, lock_state=00. All internal registers are 0.
- Latency: a valid sample at edge N enters stage 1 at N+1. If it completes a window, metric/metric_valid update at edge N+2 and lock/lock_state update at edge N+3.
- metric_valid is high for exactly one cycle per window. Windows are back-to-back with no lost samples.
- in_valid may be asserted every cycle or sparsely. Gaps stall the counter and do not affect the result.
- sys_rst asserted mid-window discards the partial window. The first metric after release needs a full 2^WIN_LOG2 samples.

## Test plan
(Bench parameters: WIN_LOG2=4, LOCK_THR=1000, UNLOCK_THR=200, LOCK_COUNT=3, UNLOCK_COUNT=2.)
- Reset: hold sys_rst with random inputs → metric=0, metric_valid=0, lock=0, lock_state=00. Then pulse sys_rst mid-window → the next metric appears only after 16 fresh samples.
- Acquisition: I=100, Q=0, in_valid continuous → metric=1600 two cycles after each 16th sample. lock_state goes 01, 01, 10, and lock rises 3 cycles after the third window's last sample.
- Saturation: I=−32768, Q=−1 for 16 samples → metric=16·(32767−1)=524256.
- Hysteresis: from LOCKED, one window of I=0, Q=100 (metric=−1600) → HOLD with lock=1. Then a window with metric=500 → LOCKED. Then two consecutive −1600 windows → UNLOCKED, lock=0. In ACQUIRE, a 500 window → UNLOCKED.
- Sparse valid: I=50, Q=10, in_valid every third cycle → metric=640 per window, with metric_valid spaced 48 cycles apart.
- clr: assert clr with in_valid on the 8th sample of a window → that sample is dropped, lock=0, lock_state=00, metric unchanged. The next metric covers exactly 16 post-clr samples.
